// File: rtl/tbec_pkg.sv
// Shared types for the TBEC correction monitor: error-code enum, data width,
// FIFO occupancy states and the per-word payload carried through the FIFO.
package tbec_pkg;

  localparam int TBEC_DATA_W = 16;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    REGION1 = 2'd1,
    REGION2 = 2'd2,
    REGION3 = 2'd3
  } tbec_code_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } tbec_occ_e;

  // Address width is a top-level parameter, so the full entry wraps this word
  // together with the address inside the top module.
  typedef struct packed {
    logic [TBEC_DATA_W-1:0] data;
    tbec_code_e             code;
  } tbec_word_t;

endpackage

// File: rtl/tbec_skid_fifo.sv
// Two-entry elastic FIFO with an explicit EMPTY/ONE/FULL occupancy machine.
// The head register drives the output directly so it is stable under backpressure.
module tbec_skid_fifo
  import tbec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_entry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_entry
);

  tbec_occ_e    state;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         push;
  logic         pop;

  assign in_ready  = (state != OCC_FULL);
  assign out_valid = (state != OCC_EMPTY);
  assign out_entry = head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: the storage registers are reset too, because out_data/out_code/out_addr
  // must read 0 out of reset; sequential state always uses non-blocking assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OCC_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (push) begin
            head  <= in_entry;
            state <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({push, pop})
            2'b10: begin
              tail  <= in_entry;
              state <= OCC_FULL;
            end
            2'b01: state <= OCC_EMPTY;
            2'b11: head <= in_entry;
            default: ;
          endcase
        end
        OCC_FULL: begin
          if (pop) begin
            head  <= tail;
            state <= OCC_ONE;
          end
        end
        default: state <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/tbec_correction_monitor.sv
// TBEC correction monitor: buffers decoded words, counts corrections per region,
// raises a sticky threshold irq. Optional first-error log under TBEC_CORR_LOG_EN.
module tbec_correction_monitor
  import tbec_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 16,
  parameter int IRQ_THRESH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TBEC_DATA_W-1:0] in_data,
  input  logic [1:0]             in_code,
  input  logic [ADDR_W-1:0]      in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TBEC_DATA_W-1:0] out_data,
  output logic [1:0]             out_code,
  output logic [ADDR_W-1:0]      out_addr,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       cnt_r1,
  output logic [CNT_W-1:0]       cnt_r2,
  output logic [CNT_W-1:0]       cnt_r3,
  output logic                   irq,
  output logic                   log_valid,
  output logic [ADDR_W-1:0]      log_addr,
  output logic [1:0]             log_code
);

  typedef struct packed {
    tbec_word_t        word;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX        = '1;
  localparam logic [CNT_W+1:0] IRQ_SUM_THRESH = (CNT_W+2)'(IRQ_THRESH);

  entry_t in_entry;
  entry_t out_entry;
  logic   push;

  assign in_entry.word.data = in_data;
  assign in_entry.word.code = tbec_code_e'(in_code);
  assign in_entry.addr      = in_addr;

  tbec_skid_fifo #(.W($bits(entry_t))) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_entry (out_entry)
  );

  assign out_data = out_entry.word.data;
  assign out_code = out_entry.word.code;
  assign out_addr = out_entry.addr;
  assign push     = in_valid && in_ready;

  logic [2:0][CNT_W-1:0] cnt_q;
  logic [2:0][CNT_W-1:0] cnt_d;
  logic [CNT_W+1:0]      cnt_sum;
  logic                  irq_d;

  // A clear and a push in the same cycle: the clear wins first, then the push
  // still counts, so the event is never lost.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_sum = '0;
    cnt_d   = cnt_q;
    for (int k = 0; k < 3; k++) begin
      if (cnt_clr) cnt_d[k] = '0;
      if (push && (in_code == 2'(k + 1)) && (cnt_d[k] != CNT_MAX))
        cnt_d[k] = cnt_d[k] + CNT_W'(1);
      cnt_sum = cnt_sum + (CNT_W+2)'(cnt_d[k]);
    end
    irq_d = (irq && !cnt_clr) || (cnt_sum >= IRQ_SUM_THRESH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      irq   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq   <= irq_d;
    end
  end

  assign cnt_r1 = cnt_q[0];
  assign cnt_r2 = cnt_q[1];
  assign cnt_r3 = cnt_q[2];

`ifdef TBEC_CORR_LOG_EN
  logic log_take;

  assign log_take = push && (in_code != 2'(NONE)) && (!log_valid || cnt_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_valid <= 1'b0;
      log_addr  <= '0;
      log_code  <= '0;
    end else if (log_take) begin
      log_valid <= 1'b1;
      log_addr  <= in_addr;
      log_code  <= in_code;
    end else if (cnt_clr) begin
      log_valid <= 1'b0;
      log_addr  <= '0;
      log_code  <= '0;
    end
  end
`else
  assign log_valid = 1'b0;
  assign log_addr  = '0;
  assign log_code  = '0;
`endif

endmodule

// File: tb/tb_tbec_correction_monitor.sv
// Bench for tbec_correction_monitor: directed steps plus random traffic,
// checked against a queue-and-integer reference model.
module tb_tbec_correction_monitor;

  localparam int ADDR_W     = 10;
  localparam int CNT_W      = 3;
  localparam int IRQ_THRESH = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef TBEC_CORR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic [1:0]        in_code;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [1:0]        out_code;
  logic [ADDR_W-1:0] out_addr;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cnt_r1;
  logic [CNT_W-1:0]  cnt_r2;
  logic [CNT_W-1:0]  cnt_r3;
  logic              irq;
  logic              log_valid;
  logic [ADDR_W-1:0] log_addr;
  logic [1:0]        log_code;

  tbec_correction_monitor #(
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W),
    .IRQ_THRESH (IRQ_THRESH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_code   (in_code),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_code  (out_code),
    .out_addr  (out_addr),
    .cnt_clr   (cnt_clr),
    .cnt_r1    (cnt_r1),
    .cnt_r2    (cnt_r2),
    .cnt_r3    (cnt_r3),
    .irq       (irq),
    .log_valid (log_valid),
    .log_addr  (log_addr),
    .log_code  (log_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]       d;
    logic [1:0]        c;
    logic [ADDR_W-1:0] a;
  } ent_t;

  ent_t              m_q[$];
  int                m_cnt[1:3];
  bit                m_irq;
  bit                m_log_v;
  logic [ADDR_W-1:0] m_log_a;
  logic [1:0]        m_log_c;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    for (int k = 1; k <= 3; k++) m_cnt[k] = 0;
    m_irq   = 1'b0;
    m_log_v = 1'b0;
    m_log_a = '0;
    m_log_c = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'(m_q.size() < 2));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check({tag, ".out_data"}, 32'(out_data), 32'(m_q[0].d));
      check({tag, ".out_code"}, 32'(out_code), 32'(m_q[0].c));
      check({tag, ".out_addr"}, 32'(out_addr), 32'(m_q[0].a));
    end
    check({tag, ".cnt_r1"},    32'(cnt_r1),    32'(m_cnt[1]));
    check({tag, ".cnt_r2"},    32'(cnt_r2),    32'(m_cnt[2]));
    check({tag, ".cnt_r3"},    32'(cnt_r3),    32'(m_cnt[3]));
    check({tag, ".irq"},       32'(irq),       32'(m_irq));
    check({tag, ".log_valid"}, 32'(log_valid), 32'(m_log_v));
    check({tag, ".log_addr"},  32'(log_addr),  32'(m_log_a));
    check({tag, ".log_code"},  32'(log_code),  32'(m_log_c));
  endtask

  // Drive one cycle of inputs, check the state the model expects before the
  // edge, then advance the model by that edge.
  task automatic step(input string tag, input logic v, input logic [15:0] d,
                      input logic [1:0] c, input logic [ADDR_W-1:0] a,
                      input logic ordy, input logic clr);
    bit   do_push;
    bit   do_pop;
    ent_t e;
    in_valid  = v;
    in_data   = d;
    in_code   = c;
    in_addr   = a;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    check_all(tag);
    do_push = v && (m_q.size() < 2);
    do_pop  = ordy && (m_q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      e.d = d; e.c = c; e.a = a;
      m_q.push_back(e);
    end
    if (clr) begin
      for (int k = 1; k <= 3; k++) m_cnt[k] = 0;
      m_irq = 1'b0;
      if (LOG_EN) begin
        m_log_v = 1'b0; m_log_a = '0; m_log_c = '0;
      end
    end
    if (do_push && c != 2'd0 && m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
    if (m_cnt[1] + m_cnt[2] + m_cnt[3] >= IRQ_THRESH) m_irq = 1'b1;
    if (LOG_EN && do_push && c != 2'd0 && !m_log_v) begin
      m_log_v = 1'b1; m_log_a = a; m_log_c = c;
    end
    @(negedge clk);
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    model_clear();
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_data"},  32'(out_data),  32'd0);
    check({tag, ".out_code"},  32'(out_code),  32'd0);
    check({tag, ".out_addr"},  32'(out_addr),  32'd0);
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_data = '0; in_code = '0; in_addr = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    model_clear();
    #2;
    reset_now("reset");

    // Single word, no error code
    step("first_push", 1'b1, 16'hA5A5, 2'd0, 10'd5, 1'b1, 1'b0);
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_out_data",  32'(out_data),  32'h0000A5A5);
    check("first_out_addr",  32'(out_addr),  32'd5);
    step("first_drain", 1'b0, 16'h0, 2'd0, 10'd0, 1'b1, 1'b0);

    // Backpressure: third word stalls until the consumer drains
    step("stall_w0", 1'b1, 16'h1111, 2'd0, 10'd1, 1'b0, 1'b0);
    step("stall_w1", 1'b1, 16'h2222, 2'd0, 10'd2, 1'b0, 1'b0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    step("stall_w2", 1'b1, 16'h3333, 2'd0, 10'd3, 1'b0, 1'b0);
    step("drain_0",  1'b1, 16'h3333, 2'd0, 10'd3, 1'b1, 1'b0);
    step("drain_1",  1'b1, 16'h3333, 2'd0, 10'd3, 1'b1, 1'b0);
    step("drain_2",  1'b0, 16'h0,    2'd0, 10'd0, 1'b1, 1'b0);
    step("drain_3",  1'b0, 16'h0,    2'd0, 10'd0, 1'b1, 1'b0);

    // Region counters and threshold interrupt
    step("code1", 1'b1, 16'h0101, 2'd1, 10'd10, 1'b1, 1'b0);
    step("code2", 1'b1, 16'h0202, 2'd2, 10'd11, 1'b1, 1'b0);
    step("code3", 1'b1, 16'h0303, 2'd3, 10'd12, 1'b1, 1'b0);
    check("irq_below_thresh", 32'(irq), 32'd0);
    step("code3b", 1'b1, 16'h0304, 2'd3, 10'd13, 1'b1, 1'b0);
    check("irq_at_thresh", 32'(irq), 32'd1);
    check("cnt_r3_two",    32'(cnt_r3), 32'd2);
    step("irq_hold", 1'b0, 16'h0, 2'd0, 10'd0, 1'b1, 1'b0);
    check("irq_sticky", 32'(irq), 32'd1);
    step("clr", 1'b0, 16'h0, 2'd0, 10'd0, 1'b1, 1'b1);
    check("irq_cleared", 32'(irq), 32'd0);
    check("cnt_r1_cleared", 32'(cnt_r1), 32'd0);

    // Clear coinciding with a region-2 push on a saturated counter
    for (int i = 0; i < 8; i++)
      step("r2_fill", 1'b1, 16'(i), 2'd2, 10'(i), 1'b1, 1'b0);
    check("r2_saturated", 32'(cnt_r2), 32'd7);
    step("clr_push", 1'b1, 16'hBEEF, 2'd2, 10'd99, 1'b1, 1'b1);
    check("r2_after_clr_push", 32'(cnt_r2), 32'd1);

    // Saturation of region 1
    step("clr2", 1'b0, 16'h0, 2'd0, 10'd0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++)
      step("r1_sat", 1'b1, 16'(i + 100), 2'd1, 10'(i), 1'b1, 1'b0);
    check("r1_saturated", 32'(cnt_r1), 32'd7);

    // First-error log, then reset with words still buffered
    step("clr3", 1'b0, 16'h0, 2'd0, 10'd0, 1'b1, 1'b1);
    step("log_c0", 1'b1, 16'hC000, 2'd0, 10'd9,  1'b0, 1'b0);
    step("log_c3", 1'b1, 16'hC003, 2'd3, 10'd12, 1'b0, 1'b0);
    step("log_c1", 1'b1, 16'hC001, 2'd1, 10'd20, 1'b1, 1'b0);
    step("log_c1b", 1'b1, 16'hC001, 2'd1, 10'd20, 1'b0, 1'b0);
    check("log_addr_first", 32'(log_addr),  LOG_EN ? 32'd12 : 32'd0);
    check("log_code_first", 32'(log_code),  LOG_EN ? 32'd3  : 32'd0);
    check("log_valid_set",  32'(log_valid), LOG_EN ? 32'd1  : 32'd0);
    #2;
    reset_now("mid_reset");

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), 16'($urandom),
           2'($urandom_range(0, 3)), 10'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    step("final", 1'b0, 16'h0, 2'd0, 10'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
